led_p2s_sched: RTL and testbench

- Controller that sequences the 16-bit LED parallel-to-serial shifter (LED_DRV-class datapath: start in, finish out).
- Arbitrates two pattern requesters round-robin and issues a one-cycle start with latched data.
- Waits for finish, then enforces an inter-frame gap.
- Re-sends the last pattern periodically, so the LED chain recovers from glitches without requester traffic.

---
 rtl/led_p2s_pkg.sv | 27 ++
 rtl/led_p2s_sched_rr_arb2.sv | 46 ++++
 rtl/led_p2s_sched.sv | 191 +++++++++++++++++++
 tb/tb_led_p2s_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_p2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_p2s_pkg
// Description : Shared definitions for the LED parallel-to-serial scheduler:
//               default frame width, controller state encoding and a helper
//               that sizes down-counters from their cycle count.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package led_p2s_pkg;

   localparam int LED_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_e;

   // Bits needed to hold the values 0 .. n_vals-1 (never less than one bit).
   function automatic int cnt_w(input int n_vals);
      return (n_vals < 2) ? 1 : $clog2(n_vals);
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_p2s_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. The grant is combinational from
//               the request vector; the priority pointer moves to the side
//               that did not win whenever advance_i is high and a grant is
//               issued.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset (pointer -> 0)
//               req_i     - request vector {req1, req0}
//               advance_i - commit the current grant and rotate priority
//               grant_o   - one-hot grant (all zero when nothing requested)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   logic ptr_q;
   logic ptr_d;

   // A lone requester always wins; a tie goes to the side the pointer names.
   always_comb begin
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After a win, the loser side gets priority: winner 0 -> ptr 1, winner 1 -> ptr 0.
   assign ptr_d = (advance_i && (req_i != 2'b00)) ? grant_o[0] : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_p2s_sched.sv
`default_nettype none
// ============================================================================
// Module      : led_p2s_sched
// Description : Sequencer for a 16-bit LED parallel-to-serial shifter.
//               Arbitrates two requesters round-robin, issues a one-cycle
//               start with the latched frame, waits for finish, holds an
//               inter-frame gap and periodically re-sends the last frame.
//               Optional WAIT timeout: define LED_SCHED_TIMEOUT_EN.
// Ports       : clk, rst_n           - clock, async active-low reset
//               req0/data0/gnt0      - requester 0 (level req, grant pulse)
//               req1/data1/gnt1      - requester 1
//               p2s_start/p2s_data   - start pulse and held frame to shifter
//               p2s_finish           - shifter done
//               led_clr_n            - LED chain clear (low during reset)
//               busy                 - state is START, WAIT or GAP
//               err                  - sticky WAIT timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module led_p2s_sched #(
   parameter int LED_W       = led_p2s_pkg::LED_W,
   parameter int REFRESH_CYC = 1000,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [LED_W-1:0] data0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [LED_W-1:0] data1,
   output logic             gnt1,
   output logic             p2s_start,
   output logic [LED_W-1:0] p2s_data,
   input  logic             p2s_finish,
   output logic             led_clr_n,
   output logic             busy,
   output logic             err
);

   import led_p2s_pkg::*;

   localparam int REF_W = cnt_w(REFRESH_CYC);
   localparam int GAP_W = cnt_w(GAP_CYC);

   // Parameter sanity, caught at elaboration.
   if (REFRESH_CYC < 2) begin : g_bad_refresh
      $error("REFRESH_CYC must be at least 2");
   end
   if (GAP_CYC < 1) begin : g_bad_gap
      $error("GAP_CYC must be at least 1");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_e             state_q;
   logic [REF_W-1:0]   refresh_q;
   logic [GAP_W-1:0]   gap_q;
   logic [LED_W-1:0]   data_q;
   logic               have_last_q;
   logic               gnt0_q;
   logic               gnt1_q;
   logic               start_q;
   logic               clr_n_q;
   logic               busy_q;

   logic [1:0]         req_vec;
   logic [1:0]         arb_grant;
   logic               arb_adv;

   assign req_vec = {req1, req0};
   // The pointer only rotates when IDLE actually hands out a grant.
   assign arb_adv = (state_q == IDLE);

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_vec),
      .advance_i (arb_adv),
      .grant_o   (arb_grant)
   );

`ifdef LED_SCHED_TIMEOUT_EN
   localparam int TMO_W = cnt_w(TIMEOUT_CYC);
   logic [TMO_W-1:0] wait_q;
   logic             err_q;
   logic             tmo_hit;

   // True in the last permitted WAIT cycle.
   assign tmo_hit = (wait_q == TMO_W'(TIMEOUT_CYC - 1));
   assign err     = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         refresh_q   <= REF_W'(REFRESH_CYC - 1);
         gap_q       <= '0;
         data_q      <= '0;
         have_last_q <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         start_q     <= 1'b0;
         clr_n_q     <= 1'b0;
         busy_q      <= 1'b0;
`ifdef LED_SCHED_TIMEOUT_EN
         wait_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         clr_n_q <= 1'b1;
         start_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         if (refresh_q != '0) begin
            refresh_q <= refresh_q - 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (arb_grant != 2'b00) begin
                  data_q      <= arb_grant[1] ? data1 : data0;
                  gnt0_q      <= arb_grant[0];
                  gnt1_q      <= arb_grant[1];
                  have_last_q <= 1'b1;
                  start_q     <= 1'b1;
                  busy_q      <= 1'b1;
                  refresh_q   <= REF_W'(REFRESH_CYC - 1);
                  state_q     <= START;
               end else if ((refresh_q == '0) && have_last_q) begin
                  // Auto-resend: frame register keeps the last pattern.
                  start_q     <= 1'b1;
                  busy_q      <= 1'b1;
                  refresh_q   <= REF_W'(REFRESH_CYC - 1);
                  state_q     <= START;
               end
            end

            START: begin
               // A finish seen here belongs to no frame of ours; ignore it.
               state_q <= WAIT;
`ifdef LED_SCHED_TIMEOUT_EN
               wait_q  <= '0;
`endif
            end

            WAIT: begin
               if (p2s_finish) begin
                  gap_q   <= '0;
                  state_q <= GAP;
               end
`ifdef LED_SCHED_TIMEOUT_EN
               else if (tmo_hit) begin
                  err_q   <= 1'b1;
                  gap_q   <= '0;
                  state_q <= GAP;
               end else begin
                  wait_q  <= wait_q + 1'b1;
               end
`endif
            end

            GAP: begin
               if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gap_q   <= gap_q + 1'b1;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign p2s_start = start_q;
   assign p2s_data  = data_q;
   assign led_clr_n = clr_n_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_p2s_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_p2s_sched
// Description : Directed self-checking bench for led_p2s_sched with
//               REFRESH_CYC=20, GAP_CYC=4, TIMEOUT_CYC=64. Inputs change 1ns
//               after a rising edge; outputs are sampled at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_p2s_sched;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        req0       = 1'b0;
   logic        req1       = 1'b0;
   logic [15:0] data0      = 16'h0;
   logic [15:0] data1      = 16'h0;
   logic        p2s_finish = 1'b0;
   logic        gnt0;
   logic        gnt1;
   logic        p2s_start;
   logic [15:0] p2s_data;
   logic        led_clr_n;
   logic        busy;
   logic        err;

   int n_chk  = 0;
   int n_pass = 0;

   led_p2s_sched #(
      .LED_W       (16),
      .REFRESH_CYC (20),
      .GAP_CYC     (4),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .data0      (data0),
      .gnt0       (gnt0),
      .req1       (req1),
      .data1      (data1),
      .gnt1       (gnt1),
      .p2s_start  (p2s_start),
      .p2s_data   (p2s_data),
      .p2s_finish (p2s_finish),
      .led_clr_n  (led_clr_n),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns the number of edges until p2s_start is seen (bounded).
   task automatic wait_start(input int max_cyc, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!p2s_start && (n < max_cyc));
      check("start_seen", {31'd0, p2s_start}, 32'd1);
   endtask

   // One-cycle finish pulse; returns 1ns after the edge that sampled it.
   task automatic send_finish();
      p2s_finish = 1'b1;
      step();
      p2s_finish = 1'b0;
   endtask

   initial begin
      int n;
      int seen;

      // ---------------- reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  {31'd0, busy},       32'd0);
      check("rst_start", {31'd0, p2s_start},  32'd0);
      check("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
      check("rst_data",  {16'd0, p2s_data},   32'd0);
      check("rst_clr",   {31'd0, led_clr_n},  32'd0);
      check("rst_err",   {31'd0, err},        32'd0);
      rst_n = 1'b1;
      step();
      check("clr_rise",  {31'd0, led_clr_n},  32'd1);

      // ---------------- no frame yet: refresh must never fire
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (p2s_start) seen++;
      end
      check("cold_no_start", seen, 0);

      // ---------------- single frame from requester 0
      req0 = 1'b1; data0 = 16'hA5A5;
      step();
      check("b_gnt", {30'd0, gnt1, gnt0}, 32'd1);
      check("b_start", {31'd0, p2s_start}, 32'd1);
      check("b_data", {16'd0, p2s_data}, 32'h0000_A5A5);
      check("b_busy", {31'd0, busy}, 32'd1);
      req0 = 1'b0; data0 = 16'h0000;
      step();
      check("b_pulse_len", {29'd0, gnt1, gnt0, p2s_start}, 32'd0);
      check("b_data_held", {16'd0, p2s_data}, 32'h0000_A5A5);
      repeat (2) step();
      send_finish();
      repeat (3) step();
      check("b_gap_busy", {31'd0, busy}, 32'd1);
      step();
      check("b_gap_done", {31'd0, busy}, 32'd0);

      // ---------------- finish in START ignored, req1 pending during WAIT
      req0 = 1'b1; data0 = 16'hBEEF;
      step();
      check("c_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
      check("c_data", {16'd0, p2s_data}, 32'h0000_BEEF);
      req0 = 1'b0; p2s_finish = 1'b1;
      step();
      p2s_finish = 1'b0;
      req1 = 1'b1; data1 = 16'h1234;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (gnt1 || p2s_start) seen++;
      end
      check("c_wait_hold", seen, 0);
      check("c_wait_busy", {31'd0, busy}, 32'd1);
      send_finish();
      wait_start(20, n);
      check("c_gnt1_lat", n, 5);
      check("c_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
      check("c_data1", {16'd0, p2s_data}, 32'h0000_1234);
      req1 = 1'b0;

      // ---------------- periodic refresh of the last frame
      step();
      send_finish();
      wait_start(40, n);
      check("r_period", n + 2, 20);
      check("r_no_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      check("r_data", {16'd0, p2s_data}, 32'h0000_1234);

      // ---------------- round robin with both requesters held
      req0 = 1'b1; data0 = 16'h00FF;
      req1 = 1'b1; data1 = 16'hFF00;
      step();
      send_finish();
      for (int i = 0; i < 4; i++) begin
         wait_start(20, n);
         check("rr_lat", n, 5);
         check("rr_gnt", {30'd0, gnt1, gnt0}, (i % 2) ? 32'd2 : 32'd1);
         check("rr_data", {16'd0, p2s_data}, (i % 2) ? 32'h0000_FF00 : 32'h0000_00FF);
         if (i == 3) begin
            req1 = 1'b0; data0 = 16'hCAFE;
         end
         step();
         send_finish();
      end

      // ---------------- reset in the middle of WAIT
      wait_start(20, n);
      check("e_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
      step();
      #2 rst_n = 1'b0;
      #1;
      check("e_async_busy", {31'd0, busy}, 32'd0);
      check("e_async_clr", {31'd0, led_clr_n}, 32'd0);
      check("e_async_data", {16'd0, p2s_data}, 32'd0);
      #1 rst_n = 1'b1;
      step();
      check("e_clr_rise", {31'd0, led_clr_n}, 32'd1);
      check("e_regrant", {29'd0, gnt1, gnt0, p2s_start}, 32'd3);
      check("e_data", {16'd0, p2s_data}, 32'h0000_CAFE);
      req0 = 1'b0;
      step();
      send_finish();

`ifdef LED_SCHED_TIMEOUT_EN
      // ---------------- finish on the last allowed WAIT cycle is success
      req1 = 1'b1; data1 = 16'h5A5A;
      wait_start(20, n);
      req1 = 1'b0;
      repeat (64) step();
      send_finish();
      check("t_edge_ok", {31'd0, err}, 32'd0);

      // ---------------- finish withheld -> timeout
      req0 = 1'b1; data0 = 16'h0F0F;
      wait_start(20, n);
      check("t_lat", n, 5);
      req0 = 1'b0;
      repeat (64) step();
      check("t_err_pre", {31'd0, err}, 32'd0);
      step();
      check("t_err_set", {31'd0, err}, 32'd1);
      check("t_gap_busy", {31'd0, busy}, 32'd1);
      repeat (3) step();
      check("t_gap_last", {31'd0, busy}, 32'd1);
      step();
      check("t_idle", {31'd0, busy}, 32'd0);
      // refresh is due now, but the request must win
      req1 = 1'b1; data1 = 16'h7E7E;
      wait_start(20, n);
      check("t_req_wins", {30'd0, gnt1, gnt0}, 32'd2);
      check("t_req_data", {16'd0, p2s_data}, 32'h0000_7E7E);
      req1 = 1'b0;
      step();
      send_finish();
      check("t_err_sticky", {31'd0, err}, 32'd1);
`else
      // ---------------- finish withheld: WAIT holds indefinitely
      req1 = 1'b1; data1 = 16'h5A5A;
      wait_start(20, n);
      check("t_lat", n, 5);
      req1 = 1'b0;
      repeat (70) step();
      check("t_still_busy", {31'd0, busy}, 32'd1);
      check("t_no_err", {31'd0, err}, 32'd0);
      send_finish();
      repeat (4) step();
      check("t_idle", {31'd0, busy}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "simulation watchdog expired");
   end

endmodule
`default_nettype wire
